data_ram_responder: RTL and testbench
=====================================

// Module: data_ram_responder
// PURPOSE
// - Data-side RAM responder: the memory end of the MEM-stage request interface (ram_en/ram_write_en/ram_addr/ram_write_data).
// - Holds a word-organised array with per-byte-lane writes, inserts programmable wait states and stalls the pipeline until the access completes.
// - Returns the full aligned read word; lane selection and sign extension are done downstream in WB.
// PARAMETERS
// - ADDR_WIDTH   10            word-index bits; the array holds 2**ADDR_WIDTH 32-bit words (default 4 KiB)
// - WAIT_CYCLES  0             extra wait cycles per access, 0..15
// - BASE_ADDR    32'h0000_0000 byte address of word 0
// PORTS
// - clk             in   1   clock, rising edge
// - rst             in   1   reset, asynchronous, active-high
// - ram_en          in   1   request valid; held stable by the pipeline while ram_stall=1
// - ram_write_en    in   4   byte-lane write mask; 4'b0000 with ram_en=1 means read
// - ram_addr        in   32  byte address; bits [1:0] ignored (the initiator sends it word-aligned)
// - ram_write_data  in   32  lane-positioned write data
// - ram_read_data   out  32  read word; registered, held until the next read completes
// - ram_valid       out  1   one-cycle pulse: access complete
// - ram_stall       out  1   pipeline hold request
// - ram_err         out  1   out-of-range access flag (see CONFIGURATION)
// BEHAVIOUR
// - Reset: state=IDLE; ram_read_data=0, ram_valid=0, ram_err=0; ram_stall forced 0 while rst=1. Array contents are not reset.
// - index = (ram_addr - BASE_ADDR) >> 2, truncated to ADDR_WIDTH bits.
// - FSM IDLE -> ACCESS -> DONE -> IDLE, with a 4-bit wait counter:
//   - IDLE: ram_stall = ram_en (combinational). If ram_en=1 at the edge, latch addr, mask and data, load counter=WAIT_CYCLES, go to ACCESS.
//   - ACCESS: ram_stall=1. While counter!=0, decrement. When counter==0, perform the access at this edge and go to DONE:
//     - write: array[index] byte k <= ram_write_data byte k for each set mask bit k.
//     - read: ram_read_data <= array[index].
//   - DONE: ram_valid=1, ram_stall=0. The pipeline advances at this edge; go to IDLE unconditionally.
// - Latency for a request first seen in IDLE in cycle N:
//   - ram_stall is high in cycles N..N+WAIT_CYCLES+1.
//   - ram_valid is high in cycle N+WAIT_CYCLES+2.
//   - A new request is accepted no earlier than N+WAIT_CYCLES+3, so each access occupies WAIT_CYCLES+3 cycles.
// - Input changes during ACCESS or DONE are ignored; the latched request completes even if ram_en drops.
// - A write leaves ram_read_data unchanged. A read-after-write to the same word returns the new data, because the accesses are serialised.
// - Reset during ACCESS: the latched request is discarded, no partial write occurs, ram_valid stays 0.
// - ram_en=1 with mask 0000 is a read. A write with mask 0000 cannot be issued, because the initiator zeroes the mask on misalignment.
// CONFIGURATION
// - DATA_RAM_BOUND_CHECK_EN defined:
//   - Latched address outside [BASE_ADDR, BASE_ADDR + 4*2**ADDR_WIDTH) is out of range.
//   - For such an access the write is suppressed, the read returns 32'h0, and ram_err=1 in the DONE cycle together with ram_valid.
// - Not defined: ram_err is tied 0 and the index wraps, with upper address bits ignored.
// TESTING
// - WAIT_CYCLES=0: write 0xDEADBEEF, mask 1111, addr 0x10; then read 0x10 -> stall for 2 cycles, valid in the 3rd cycle, ram_read_data=0xDEADBEEF.
// - Byte write: mask 0100, data 0x00AA0000 to 0x10, then read 0x10 -> 0xDEAABEEF; a halfword write with mask 1100, data 0x12340000 -> 0x1234BEEF.
// - WAIT_CYCLES=3, read in cycle N -> ram_stall high N..N+4, ram_valid pulse exactly at N+5, ram_read_data stable afterwards.
// - Back-to-back: 4 reads with ram_en held and the pipeline advancing on valid -> 4 valid pulses, spaced WAIT_CYCLES+3 cycles apart, correct data each.
// - Reset asserted in ACCESS of a write of 0xFFFFFFFF to 0x20 -> after reset, a read of 0x20 returns the prior value; ram_valid never pulses for the aborted write.
// - ADDR_WIDTH=10: write 0x5A5A5A5A to 0x1000.
//   - With the macro: ram_err=1 with valid, and a read of 0x0 is unchanged.
//   - Without the macro: a read of 0x0 returns 0x5A5A5A5A, and ram_err stays 0.

Source files
------------

// File: rtl/data_ram_responder.sv
// -----------------------------------------------------------------------------
// data_ram_responder
//   Memory end of the MEM-stage data request interface. Holds a word-organised
//   RAM with per-byte-lane writes, inserts WAIT_CYCLES wait states per access,
//   and stalls the pipeline until the access completes. The full aligned word
//   is returned; lane selection and sign extension happen downstream.
//
//   Optional feature macro: DATA_RAM_BOUND_CHECK_EN
//     defined   : accesses outside [BASE_ADDR, BASE_ADDR + 4*2**ADDR_WIDTH)
//                 suppress the write, read back 0 and raise ram_err with
//                 ram_valid.
//     undefined : ram_err stays 0, the word index wraps.
//
// Ports
//   clk            in   1   clock, rising edge
//   rst            in   1   asynchronous active-high reset
//   ram_en         in   1   request valid (held while ram_stall=1)
//   ram_write_en   in   4   byte-lane write mask, 0000 = read
//   ram_addr       in   32  byte address, bits [1:0] ignored
//   ram_write_data in   32  lane-positioned write data
//   ram_read_data  out  32  registered read word, held until next read
//   ram_valid      out  1   one-cycle access-complete pulse
//   ram_stall      out  1   pipeline hold request
//   ram_err        out  1   out-of-range access flag (with ram_valid)
// -----------------------------------------------------------------------------
module data_ram_responder #(
    parameter int          ADDR_WIDTH  = 10,
    parameter int          WAIT_CYCLES = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ram_en,
    input  logic [3:0]  ram_write_en,
    input  logic [31:0] ram_addr,
    input  logic [31:0] ram_write_data,
    output logic [31:0] ram_read_data,
    output logic        ram_valid,
    output logic        ram_stall,
    output logic        ram_err
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  mask_q;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] idx;
    logic                  in_range;
    logic                  do_acc;
    logic                  do_wr;

    // Offset from the base, then word index; upper bits drop out (wrap).
    assign idx = ADDR_WIDTH'((addr_q - BASE_ADDR) >> 2);

`ifdef DATA_RAM_BOUND_CHECK_EN
    // Addresses below BASE_ADDR wrap to a huge offset and fail the compare.
    localparam logic [32:0] SPAN = 33'(DEPTH) << 2;
    assign in_range = ({1'b0, addr_q - BASE_ADDR} < SPAN);
`else
    assign in_range = 1'b1;
`endif

    assign do_acc = (state_q == S_ACCESS) && (cnt_q == 4'd0);
    assign do_wr  = do_acc && (mask_q != 4'b0000) && in_range;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (ram_en) begin
                    state_d = S_ACCESS;
                    cnt_d   = 4'(WAIT_CYCLES);
                end
            end
            S_ACCESS: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = S_DONE;
                    err_d   = !in_range;
                    if (mask_q == 4'b0000)
                        rdata_d = in_range ? mem[idx] : 32'h0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                err_d   = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            mask_q  <= 4'b0000;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            // Request is captured only on acceptance; later input changes are ignored.
            if (state_q == S_IDLE && ram_en) begin
                addr_q  <= ram_addr;
                wdata_q <= ram_write_data;
                mask_q  <= ram_write_en;
            end
        end
    end

    // Array is not reset. A reset aborts ACCESS via state_q, so no partial write.
    always_ff @(posedge clk) begin
        if (do_wr && !rst) begin
            for (int k = 0; k < 4; k++) begin
                if (mask_q[k])
                    mem[idx][8*k +: 8] <= wdata_q[8*k +: 8];
            end
        end
    end

    assign ram_read_data = rdata_q;
    assign ram_valid     = (state_q == S_DONE);
    assign ram_err       = ram_valid && err_q;
    assign ram_stall     = rst ? 1'b0 :
                           (state_q == S_IDLE)   ? ram_en :
                           (state_q == S_ACCESS);

endmodule

// File: tb/tb_data_ram_responder.sv
module tb_data_ram_responder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Index 0: WAIT_CYCLES=0 instance, index 1: WAIT_CYCLES=3 instance.
    logic        en  [2];
    logic [3:0]  we  [2];
    logic [31:0] ad  [2];
    logic [31:0] wd  [2];
    logic [31:0] rdo [2];
    logic        st  [2];
    logic        vl  [2];
    logic        er  [2];

    data_ram_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) u0 (
        .clk(clk), .rst(rst), .ram_en(en[0]), .ram_write_en(we[0]),
        .ram_addr(ad[0]), .ram_write_data(wd[0]), .ram_read_data(rdo[0]),
        .ram_valid(vl[0]), .ram_stall(st[0]), .ram_err(er[0]));

    data_ram_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(3), .BASE_ADDR(32'h0)) u3 (
        .clk(clk), .rst(rst), .ram_en(en[1]), .ram_write_en(we[1]),
        .ram_addr(ad[1]), .ram_write_data(wd[1]), .ram_read_data(rdo[1]),
        .ram_valid(vl[1]), .ram_stall(st[1]), .ram_err(er[1]));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic int wc(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    // Reference model: word array per instance plus the last read word.
    logic [31:0] mref    [2][1024];
    logic [31:0] last_rd [2];

    function automatic bit m_inr(input logic [31:0] a);
`ifdef DATA_RAM_BOUND_CHECK_EN
        return a < 32'h1000;     // BASE 0, 1024 words of 4 bytes
`else
        return (a == a);
`endif
    endfunction

    task automatic model(input int d, input logic [3:0] w, input logic [31:0] a,
                         input logic [31:0] dd, output logic [31:0] xr, output logic xe);
        int  word;
        bit  ok;
        word = int'((a / 4) % 1024);
        ok   = m_inr(a);
        xe   = !ok;
        if (w == 4'b0000) begin
            last_rd[d] = ok ? mref[d][word] : 32'h0;
        end else if (ok) begin
            for (int k = 0; k < 4; k++)
                if (w[k]) mref[d][word][8*k +: 8] = dd[8*k +: 8];
        end
        xr = last_rd[d];
    endtask

    // Issue one access, check stall/valid/err every cycle until the valid pulse.
    task automatic acc(input int d, input logic [3:0] w, input logic [31:0] a,
                       input logic [31:0] dd, input bit hold,
                       output logic [31:0] r, output logic e, output int vc);
        int k;
        bit done;
        @(negedge clk);
        en[d] = 1'b1; we[d] = w; ad[d] = a; wd[d] = dd;
        #1;
        k = 0; done = 0; r = 'x; e = 1'bx; vc = -1;
        while (!done && k < 40) begin
            if (k > 0) begin
                @(negedge clk);
                #1;
            end
            if (k == wc(d) + 2) begin
                chk($sformatf("d%0d done stall,valid k=%0d", d, k),
                    32'({st[d], vl[d]}), 32'b01);
                r = rdo[d]; e = er[d]; vc = cyc; done = 1;
            end else begin
                chk($sformatf("d%0d busy stall,valid,err k=%0d", d, k),
                    32'({st[d], vl[d], er[d]}), 32'b100);
            end
            k++;
        end
        if (!hold) en[d] = 1'b0;
    endtask

    task automatic op(input int d, input logic [3:0] w, input logic [31:0] a,
                      input logic [31:0] dd, input bit hold, output int vc);
        logic [31:0] r, xr;
        logic        e, xe;
        acc(d, w, a, dd, hold, r, e, vc);
        model(d, w, a, dd, xr, xe);
        chk($sformatf("d%0d rdata @%h we=%b", d, a, w), r, xr);
        chk($sformatf("d%0d err @%h", d, a), 32'(e), 32'(xe));
    endtask

    typedef struct {
        logic [3:0]  w;
        logic [31:0] a;
        logic [31:0] dd;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t tv [10];

    initial begin
        logic [31:0] r, xr, hold_v;
        logic        e, xe;
        int          vc, pvc;
        bit          macro_on;

`ifdef DATA_RAM_BOUND_CHECK_EN
        macro_on = 1;
`else
        macro_on = 0;
`endif
        tv[0] = '{4'hF, 32'h10,   32'hDEADBEEF, 32'h0,        1'b0};
        tv[1] = '{4'h0, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0};
        tv[2] = '{4'h4, 32'h10,   32'h00AA0000, 32'hDEADBEEF, 1'b0};
        tv[3] = '{4'h0, 32'h10,   32'h0,        32'hDEAABEEF, 1'b0};
        tv[4] = '{4'hC, 32'h10,   32'h12340000, 32'hDEAABEEF, 1'b0};
        tv[5] = '{4'h0, 32'h10,   32'h0,        32'h1234BEEF, 1'b0};
        tv[6] = '{4'hF, 32'h0,    32'h11223344, 32'h1234BEEF, 1'b0};
        tv[7] = '{4'hF, 32'h1000, 32'h5A5A5A5A, 32'h1234BEEF, macro_on};
        tv[8] = '{4'h0, 32'h0,    32'h0, macro_on ? 32'h11223344 : 32'h5A5A5A5A, 1'b0};
        tv[9] = '{4'h0, 32'h1000, 32'h0, macro_on ? 32'h0 : 32'h5A5A5A5A, macro_on};

        for (int d = 0; d < 2; d++) begin
            en[d] = 1'b1; we[d] = 4'h0; ad[d] = 32'h0; wd[d] = 32'h0; last_rd[d] = 32'h0;
        end

        // Reset state, with ram_en high to show stall is forced low.
        repeat (2) @(negedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d reset stall,valid,err", d), 32'({st[d], vl[d], er[d]}), 32'b000);
            chk($sformatf("d%0d reset rdata", d), rdo[d], 32'h0);
        end
        en[0] = 1'b0; en[1] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("idle stall with en=0", 32'({st[0], st[1]}), 32'b00);

        // Directed vectors on the zero-wait instance.
        for (int i = 0; i < 10; i++) begin
            acc(0, tv[i].w, tv[i].a, tv[i].dd, 1'b0, r, e, vc);
            model(0, tv[i].w, tv[i].a, tv[i].dd, xr, xe);
            chk($sformatf("vec%0d rdata", i), r, tv[i].exp_rd);
            chk($sformatf("vec%0d err", i), 32'(e), 32'(tv[i].exp_err));
        end

        // Back-to-back reads with ram_en held: spacing WAIT_CYCLES+3.
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 4; i++)
                op(d, 4'hF, 32'h40 + 32'(4*i), 32'hA0B0C000 + 32'(i), 1'b0, vc);
            pvc = 0;
            for (int i = 0; i < 4; i++) begin
                op(d, 4'h0, 32'h40 + 32'(4*i), 32'h0, i < 3, vc);
                if (i > 0)
                    chk($sformatf("d%0d b2b spacing %0d", d, i), 32'(vc - pvc), 32'(wc(d) + 3));
                pvc = vc;
            end
        end

        // Read word stays put across idle cycles and a write.
        hold_v = last_rd[1];
        repeat (4) begin
            @(negedge clk);
            #1;
            chk("d1 rdata stable idle", rdo[1], hold_v);
        end
        op(1, 4'hF, 32'h44, 32'h77777777, 1'b0, vc);

        // Reset during ACCESS aborts the write.
        op(1, 4'hF, 32'h20, 32'h0BADF00D, 1'b0, vc);
        @(negedge clk);
        en[1] = 1'b1; we[1] = 4'hF; ad[1] = 32'h20; wd[1] = 32'hFFFFFFFF;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        en[1] = 1'b0;
        #1;
        chk("abort stall,valid in reset", 32'({st[1], vl[1]}), 32'b00);
        chk("abort rdata reset", rdo[1], 32'h0);
        @(negedge clk);
        rst = 1'b0;
        last_rd[0] = 32'h0; last_rd[1] = 32'h0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1;
            chk($sformatf("abort no valid %0d", i), 32'({st[1], vl[1]}), 32'b00);
        end
        op(1, 4'h0, 32'h20, 32'h0, 1'b0, vc);

        // Randomized traffic against the model on 16 words (+ aliases above the array).
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 16; i++)
                op(d, 4'hF, 32'(4*i), $urandom, 1'b0, vc);
            op(d, 4'h0, 32'h0, 32'h0, 1'b0, vc);
            for (int i = 0; i < 30; i++) begin
                logic [3:0]  w;
                logic [31:0] a;
                w = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
                a = 32'(4 * $urandom_range(0, 15));
                if ($urandom_range(0, 3) == 0) a = a + 32'h1000;
                op(d, w, a, $urandom, 1'b0, vc);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
